// File: rtl/car_pkg.sv
// Shared drive-path definitions: actuator widths, servo limits and the arbiter state encoding.
// Imported by the arbiter top and its speed ramp.
package car_pkg;

    localparam int SPEED_W = 8;
    localparam int DEG_W   = 9;

    localparam logic [DEG_W-1:0] DEG_CENTER = 9'd95;
    localparam logic [DEG_W-1:0] DEG_MIN    = 9'd30;
    localparam logic [DEG_W-1:0] DEG_MAX    = 9'd120;

    typedef enum logic [1:0] {
        ST_DRIVE = 2'd0,
        ST_BRAKE = 2'd1,
        ST_DEAD  = 2'd2,
        ST_SAFE  = 2'd3
    } drive_state_e;

    // Keep the servo inside its mechanical travel regardless of what a source asks for
    function automatic logic [DEG_W-1:0] clamp_deg(input logic [DEG_W-1:0] deg);
        logic [DEG_W-1:0] res;
        if (deg < DEG_MIN) begin
            res = DEG_MIN;
        end else if (deg > DEG_MAX) begin
            res = DEG_MAX;
        end else begin
            res = deg;
        end
        return res;
    endfunction

endpackage

// File: rtl/drive_cmd_arbiter_speed_ramp.sv
// Motor speed register: slews toward its target by at most RAMP_STEP per tick,
// never overshooting, and drops straight to zero when force_zero_i is asserted.
module speed_ramp
    import car_pkg::*;
#(
    parameter int RAMP_STEP = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tick_i,
    input  logic               force_zero_i,
    input  logic [SPEED_W-1:0] target_i,
    output logic [SPEED_W-1:0] speed_o
);

    localparam logic [SPEED_W-1:0] STEP = SPEED_W'(RAMP_STEP);

    logic [SPEED_W-1:0] speed_q;
    logic [SPEED_W-1:0] speed_d;
    logic [SPEED_W-1:0] diff_s;
    logic [SPEED_W-1:0] step_s;
    logic               up_s;

    // Next speed: bounded step toward target on tick, immediate zero on force
    always_comb begin
        speed_d = speed_q;
        up_s    = (target_i >= speed_q);
        if (up_s) begin
            diff_s = target_i - speed_q;
        end else begin
            diff_s = speed_q - target_i;
        end
        if (diff_s > STEP) begin
            step_s = STEP;
        end else begin
            step_s = diff_s;
        end
        if (force_zero_i) begin
            speed_d = 8'd0;
        end else if (tick_i) begin
            if (up_s) begin
                speed_d = speed_q + step_s;
            end else begin
                speed_d = speed_q - step_s;
            end
        end else begin
            speed_d = speed_q;
        end
    end

    // Speed register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            speed_q <= 8'd0;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed_o = speed_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Fixed-priority arbiter for the drive actuators with ramp limiting, a braked
// dead-time before every direction reversal and an ultrasonic safety stop.
module drive_cmd_arbiter
    import car_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TICK_DIV       = 500000,
    parameter int RAMP_STEP      = 2,
    parameter int DEADTIME_TICKS = 20,
    parameter int SAFE_FWD       = 20,
    parameter int SAFE_BACK      = 9,
    parameter int SAFE_HYST      = 3
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_speed,
    input  logic [9*N_REQ-1:0]   req_degree,
    input  logic [N_REQ-1:0]     req_dir,
    input  logic [7:0]           forwardDistance,
    input  logic [7:0]           backDistance,
    output logic [SPEED_W-1:0]   speed,
    output logic [DEG_W-1:0]     degree,
    output logic                 direction,
    output logic [N_REQ-1:0]     grant,
    output logic                 safety_stop,
    output logic                 beepEnable
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEAD_W = $clog2(DEADTIME_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST  = DEAD_W'(DEADTIME_TICKS - 1);
    localparam logic [7:0]        FWD_TRIP   = 8'(SAFE_FWD);
    localparam logic [7:0]        FWD_CLEAR  = 8'(SAFE_FWD + SAFE_HYST);
    localparam logic [7:0]        BACK_TRIP  = 8'(SAFE_BACK);
    localparam logic [7:0]        BACK_CLEAR = 8'(SAFE_BACK + SAFE_HYST);

    drive_state_e        state_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    logic [DEAD_W-1:0]   dead_cnt_q;
    logic [N_REQ-1:0]    grant_q;
    logic [N_REQ-1:0]    grant_d;
    logic [DEG_W-1:0]    degree_q;
    logic                direction_q;
    logic                safety_q;
    logic                beep_q;

    logic                tick_s;
    logic [SPEED_W-1:0]  tgt_speed_s;
    logic [DEG_W-1:0]    tgt_deg_s;
    logic                tgt_dir_s;
    logic                trip_s;
    logic                clear_s;
    logic                reverse_s;
    logic [SPEED_W-1:0]  ramp_tgt_s;
    logic                force_zero_s;
    logic [SPEED_W-1:0]  speed_s;

    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Free-running ramp tick divider
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (tick_s) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Lowest set request bit wins: x & -x isolates it
    assign grant_d = req_valid & (~req_valid + N_REQ'(1));

    // Target command taken from the registered grant; idle means centred and stopping
    always_comb begin
        tgt_speed_s = 8'd0;
        tgt_deg_s   = DEG_CENTER;
        tgt_dir_s   = direction_q;
        for (int i = 0; i < N_REQ; i++) begin
            tgt_speed_s = grant_q[i] ? req_speed[8*i +: 8]  : tgt_speed_s;
            tgt_deg_s   = grant_q[i] ? req_degree[9*i +: 9] : tgt_deg_s;
            tgt_dir_s   = grant_q[i] ? req_dir[i]           : tgt_dir_s;
        end
    end

    // Safety trip/release and reversal request, all relative to the present direction
    always_comb begin
        if (direction_q) begin
            trip_s  = (forwardDistance < FWD_TRIP);
            clear_s = (forwardDistance >= FWD_CLEAR);
        end else begin
            trip_s  = (backDistance < BACK_TRIP);
            clear_s = (backDistance >= BACK_CLEAR);
        end
        reverse_s = (tgt_dir_s != direction_q) && (tgt_speed_s != 8'd0);
    end

    // Effective ramp target per state; a trip zeroes speed on the same edge it enters SAFE
    always_comb begin
        ramp_tgt_s   = 8'd0;
        force_zero_s = 1'b1;
        case (state_q)
            ST_DRIVE: begin
                ramp_tgt_s   = tgt_speed_s;
                force_zero_s = trip_s;
            end
            ST_BRAKE: begin
                ramp_tgt_s   = 8'd0;
                force_zero_s = trip_s;
            end
            ST_DEAD: begin
                ramp_tgt_s   = 8'd0;
                force_zero_s = 1'b1;
            end
            ST_SAFE: begin
                ramp_tgt_s   = 8'd0;
                force_zero_s = 1'b1;
            end
            default: begin
                ramp_tgt_s   = 8'd0;
                force_zero_s = 1'b1;
            end
        endcase
    end

    speed_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_speed_ramp (
        .clk_i        (clk_50M),
        .rst_n_i      (rst_n),
        .tick_i       (tick_s),
        .force_zero_i (force_zero_s),
        .target_i     (ramp_tgt_s),
        .speed_o      (speed_s)
    );

    // Drive FSM with grant, servo, direction and status flag registers
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q     <= ST_DRIVE;
            dead_cnt_q  <= '0;
            direction_q <= 1'b1;
            grant_q     <= '0;
            degree_q    <= DEG_CENTER;
            safety_q    <= 1'b0;
            beep_q      <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            degree_q <= clamp_deg(tgt_deg_s);
            case (state_q)
                ST_DRIVE: begin
                    if (trip_s) begin
                        state_q  <= ST_SAFE;
                        safety_q <= 1'b1;
                        beep_q   <= 1'b1;
                    end else if (reverse_s) begin
                        state_q  <= ST_BRAKE;
                        safety_q <= 1'b0;
                        beep_q   <= 1'b0;
                    end else begin
                        state_q  <= ST_DRIVE;
                        safety_q <= 1'b0;
                        beep_q   <= 1'b0;
                    end
                end
                ST_BRAKE: begin
                    if (trip_s) begin
                        state_q  <= ST_SAFE;
                        safety_q <= 1'b1;
                        beep_q   <= 1'b1;
                    end else if (tgt_dir_s == direction_q) begin
                        state_q  <= ST_DRIVE;
                        safety_q <= 1'b0;
                        beep_q   <= 1'b0;
                    end else if (speed_s == 8'd0) begin
                        state_q    <= ST_DEAD;
                        dead_cnt_q <= '0;
                        safety_q   <= 1'b0;
                        beep_q     <= 1'b1;
                    end else begin
                        state_q  <= ST_BRAKE;
                        safety_q <= 1'b0;
                        beep_q   <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    safety_q <= 1'b0;
                    if (tick_s && (dead_cnt_q == DEAD_LAST)) begin
                        state_q     <= ST_DRIVE;
                        direction_q <= ~direction_q;
                        dead_cnt_q  <= '0;
                        beep_q      <= 1'b0;
                    end else if (tick_s) begin
                        state_q    <= ST_DEAD;
                        dead_cnt_q <= dead_cnt_q + DEAD_W'(1);
                        beep_q     <= 1'b1;
                    end else begin
                        state_q <= ST_DEAD;
                        beep_q  <= 1'b1;
                    end
                end
                ST_SAFE: begin
                    if (reverse_s) begin
                        state_q    <= ST_DEAD;
                        dead_cnt_q <= '0;
                        safety_q   <= 1'b0;
                        beep_q     <= 1'b1;
                    end else if (clear_s) begin
                        state_q  <= ST_DRIVE;
                        safety_q <= 1'b0;
                        beep_q   <= 1'b0;
                    end else begin
                        state_q  <= ST_SAFE;
                        safety_q <= 1'b1;
                        beep_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_DRIVE;
                    safety_q <= 1'b0;
                    beep_q   <= 1'b0;
                end
            endcase
        end
    end

    assign speed       = speed_s;
    assign degree      = degree_q;
    assign direction   = direction_q;
    assign grant       = grant_q;
    assign safety_stop = safety_q;
    assign beepEnable  = beep_q;

endmodule

// File: doc/drive_cmd_arbiter.md
Name: drive_cmd_arbiter

Overview:
Shares the single drive actuator set (motor speed, steering servo degree, motor direction) between up to four command sources: remote control, line tracking, auto-parking and wall-follow/free-run. It grants one source by fixed priority and ramp-limits speed. It enforces a stop/dead-time before any direction reversal. It applies an ultrasonic safety stop independent of the granted source. It sits between the mode logic and the PWM/servo drivers.

Parameters:
N_REQ, 4, number of requesters; index 0 is the highest priority.
TICK_DIV, 500000, clk_50M cycles per ramp tick (10 ms).
RAMP_STEP, 2, maximum speed change per tick.
DEADTIME_TICKS, 20, ticks held at speed 0 before a direction flip.
SAFE_FWD, 20, forward stop threshold in cm.
SAFE_BACK, 9, reverse stop threshold in cm.
SAFE_HYST, 3, release hysteresis in cm.

Ports:
clk_50M  in  1  system clock; the single clock domain
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-source request; level-held
req_speed  in  8*N_REQ  source i speed at bits [8i+7:8i]
req_degree  in  9*N_REQ  source i servo degree at bits [9i+8:9i]
req_dir  in  N_REQ  per-source direction (1 = forward)
forwardDistance  in  8  front ultrasonic range, cm
backDistance  in  8  rear ultrasonic range, cm
speed  out  8  registered motor speed
degree  out  9  registered servo degree
direction  out  1  registered motor direction
grant  out  N_REQ  one-hot granted source; all zero when none
safety_stop  out  1  high while the safety override is active
beepEnable  out  1  high during safety stop and dead-time

Behaviour:
- Reset (rst_n=0 at a clk_50M edge):
  - speed=0, degree=DEG_CENTER (95), direction=1, grant=0, safety_stop=0, beepEnable=0.
  - State DRIVE; tick counter 0; dead counter 0.
- Tick: a free-running counter from 0 to TICK_DIV-1. tick=1 for one cycle at wrap. The counter is cleared by reset only.
- Arbitration: the lowest index with req_valid=1 wins. grant is registered (1-cycle latency) and may change on any cycle (no hold/lock).
- Target selection:
  - From the granted source: tgt_speed, tgt_deg, tgt_dir.
  - No grant: tgt_speed=0, tgt_deg=DEG_CENTER, tgt_dir=current direction.
- degree: follows tgt_deg with 1-cycle latency in every state, clamped to [DEG_MIN=30, DEG_MAX=120].
- Ramp (on tick only): speed moves toward its effective target by min(|diff|, RAMP_STEP). No overshoot; 8-bit arithmetic with no wrap.
- State machine:
  - DRIVE: effective target = tgt_speed.
    - If tgt_dir != direction and tgt_speed > 0, go to BRAKE.
  - BRAKE: effective target = 0.
    - When speed == 0, go to DEAD and clear the dead counter.
    - If tgt_dir returns to direction before then, go back to DRIVE.
  - DEAD: speed held at 0; beepEnable=1; the dead counter increments on tick.
    - When the count reaches DEADTIME_TICKS, flip direction and go to DRIVE.
    - Target changes during DEAD are ignored until exit.
  - SAFE: speed=0; safety_stop=1; beepEnable=1.
- Safety entry (checked every cycle from DRIVE or BRAKE):
  - Trigger: (direction==1 and forwardDistance < SAFE_FWD) or (direction==0 and backDistance < SAFE_BACK).
  - On the next cycle: speed=0 with no ramp, state SAFE.
- Safety exit:
  - If the relevant distance is >= threshold+SAFE_HYST, return to DRIVE; speed ramps up from 0.
  - If tgt_dir != direction and tgt_speed > 0 while in SAFE, go directly to DEAD. Escape in the reverse direction is allowed after the dead-time.
- Safety is not evaluated in DEAD because speed is already 0. It is re-evaluated on the first DRIVE cycle using the new direction.
- Simultaneous events: safety trigger and reversal request on the same cycle resolve to SAFE.
- Reset mid-operation: all state and outputs return to reset values on the next edge.

Decomposition:
- Shared package car_pkg holds:
  - DEG_CENTER=95, DEG_MIN=30, DEG_MAX=120.
  - The state encoding DRIVE/BRAKE/DEAD/SAFE (2-bit).
  - The speed width (8) and degree width (9).
- Sub-module speed_ramp holds the speed register, the step toward target on tick, and a force_zero input. The arbiter, FSM and counters stay in drive_cmd_arbiter.

Test Plan:
- Arbitration: req_valid=4'b0110 with speed 30 for source 1 and 50 for source 2 → grant=0010 one cycle later; the ramp toward 30 (grant-change target swap) is tested with TICK_DIV=4.
- Ramp: req 0 speed 0→35, TICK_DIV=4 → speed 2,4,…,34,35 on successive ticks with no overshoot; drop to 0 → decrements by 2 down to 0.
- Reversal: steady speed 20 forward, then req_dir=0 → BRAKE ramps to 0 → beepEnable=1 for exactly 20 ticks → direction=0 → ramp back up to 20.
- Safety forward: speed 30, forwardDistance 25→19 → speed=0 and safety_stop=1 the next cycle; at 22 still stopped; at 23 released and ramping.
- Safety escape: in SAFE forward with tgt_dir=0 → DEAD 20 ticks → direction=0 with backDistance=50 → drive; backDistance=8 → SAFE.
- Reset: rst_n=0 mid-DEAD → next edge gives speed 0, degree 95, direction 1, grant 0, beep 0; the FSM restarts in DRIVE. Degree clamp: request 200 → degree 120; request 10 → degree 30.
